// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: frames UART receiver bytes as SYNC, LEN, payload, CHK.
// It checks the length, the XOR checksum and the inter-byte timeout. It holds
// one validated payload and serves it to the consumer one byte per read strobe.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [31:0] TIMEOUT_CLKS = 32'd208320
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Rd_En,
    output logic       o_Pkt_Valid,
    output logic [7:0] o_Pkt_Len,
    output logic [7:0] o_Rd_Data,
    output logic       o_Rd_Last,
    output logic       o_Chk_Err,
    output logic       o_Len_Err,
    output logic       o_Timeout,
    output logic       o_Overrun
);

    localparam int unsigned ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [31:0] TMO_LAST  = TIMEOUT_CLKS - 32'd1;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic [7:0]  len_q;
    logic [7:0]  idx_q;
    logic [7:0]  rd_ptr_q;
    logic [7:0]  chk_q;
    logic [31:0] tmo_cnt_q;
    logic        pkt_valid_q;
    logic        chk_err_q;
    logic        len_err_q;
    logic        timeout_q;
    logic        overrun_q;

    logic [7:0]  mem [MAX_LEN];
    logic        wr_en_c;
    logic        last_c;

    assign wr_en_c = (state_q == S_PAYLOAD) && i_Rx_DV;
    assign last_c  = (rd_ptr_q == (len_q - 8'd1));

    // Payload buffer; the contents have no meaning until a frame fills it, so it has no reset.
    always_ff @(posedge i_Clock) begin
        if (wr_en_c) begin
            mem[ADDR_W'(idx_q)] <= i_Rx_Byte;
        end
    end

    // Frame parser, timeout watchdog and hold/read-out control.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_SYNC;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            rd_ptr_q    <= 8'd0;
            chk_q       <= 8'd0;
            tmo_cnt_q   <= 32'd0;
            pkt_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            chk_err_q <= 1'b0;
            len_err_q <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;

            case (state_q)
                S_SYNC: begin
                    tmo_cnt_q <= 32'd0;
                    if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                        state_q <= S_LEN;
                    end
                end

                S_LEN, S_PAYLOAD, S_CHK: begin
                    if (i_Rx_DV) begin
                        // A byte on the terminal count still wins over the timeout.
                        tmo_cnt_q <= 32'd0;
                        if (state_q == S_LEN) begin
                            if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
                                len_err_q <= 1'b1;
                                state_q   <= S_SYNC;
                            end else begin
                                len_q   <= i_Rx_Byte;
                                chk_q   <= i_Rx_Byte;
                                idx_q   <= 8'd0;
                                state_q <= S_PAYLOAD;
                            end
                        end else if (state_q == S_PAYLOAD) begin
                            chk_q <= chk_q ^ i_Rx_Byte;
                            idx_q <= idx_q + 8'd1;
                            if (idx_q == (len_q - 8'd1)) begin
                                state_q <= S_CHK;
                            end
                        end else begin
                            if (i_Rx_Byte == chk_q) begin
                                pkt_valid_q <= 1'b1;
                                rd_ptr_q    <= 8'd0;
                                state_q     <= S_HOLD;
                            end else begin
                                chk_err_q <= 1'b1;
                                state_q   <= S_SYNC;
                            end
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        timeout_q <= 1'b1;
                        tmo_cnt_q <= 32'd0;
                        state_q   <= S_SYNC;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end

                S_HOLD: begin
                    // The buffer is occupied; incoming bytes, SYNC included, are dropped.
                    if (i_Rx_DV) begin
                        overrun_q <= 1'b1;
                    end
                    if (i_Rd_En) begin
                        if (last_c) begin
                            pkt_valid_q <= 1'b0;
                            rd_ptr_q    <= 8'd0;
                            state_q     <= S_SYNC;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 8'd1;
                        end
                    end
                end

                default: begin
                    state_q <= S_SYNC;
                end
            endcase
        end
    end

    // Read-side view; every field reads as zero while no packet is held.
    assign o_Pkt_Valid = pkt_valid_q;
    assign o_Pkt_Len   = pkt_valid_q ? len_q : 8'd0;
    assign o_Rd_Data   = pkt_valid_q ? mem[ADDR_W'(rd_ptr_q)] : 8'd0;
    assign o_Rd_Last   = pkt_valid_q && last_c;
    assign o_Chk_Err   = chk_err_q;
    assign o_Len_Err   = len_err_q;
    assign o_Timeout   = timeout_q;
    assign o_Overrun   = overrun_q;

endmodule
